// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch block: FSM encoding, register-to-bus
// select codes and the width of the memory wait counter.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_AR  = 2'd1,
        MEM_WAIT = 2'd2,
        HOLD     = 2'd3
    } fetch_state_e;

    // Select codes understood by the register-to-bus mux.
    localparam logic [3:0] BUS_SEL_NONE = 4'b0000;
    localparam logic [3:0] BUS_SEL_AR   = 4'b0001;
    localparam logic [3:0] BUS_SEL_DR   = 4'b0011;
    localparam logic [3:0] BUS_SEL_AC   = 4'b0100;
    localparam logic [3:0] BUS_SEL_IR   = 4'b0101;
    localparam logic [3:0] BUS_SEL_TR   = 4'b0110;
    localparam logic [3:0] BUS_SEL_MEM  = 4'b0111;
    localparam logic [3:0] BUS_SEL_PC   = 4'b1010;

    // Wide enough for the largest supported timeout (255 cycles).
    localparam int CNT_W = 8;

    function automatic logic [3:0] fetch_bus_sel(input fetch_state_e st,
                                                 input logic [3:0]   pc_code);
        return (st == LOAD_AR) ? pc_code : BUS_SEL_NONE;
    endfunction

endpackage

// File: rtl/instr_fetch_timer.sv
// Memory-wait counter: cleared outside the wait state, counts wait cycles and flags
// the last allowed cycle so the FSM can give up on the same edge.
module fetch_timer
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the TIMEOUT-th wait cycle, i.e. the last one an ack may arrive in.
    assign expired_o = enable_i && (count_q == LAST_CNT);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: routes PC onto the bus into AR, issues a memory read,
// captures the returned word into IR and holds it until the decoder takes it.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int         DATA_W  = 16,
    parameter int         TIMEOUT = 15,
    parameter logic [3:0] SEL_PC  = BUS_SEL_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [3:0]        bus_sel,
    output logic              bus_own,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pc_inc,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_taken,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              pc_inc_q, pc_inc_d;
    logic              fetch_err_q, fetch_err_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        ar_d         = ar_q;
        ir_d         = ir_q;
        pc_inc_d     = 1'b0;
        fetch_err_d  = 1'b0;
        timer_clear  = (state_q != MEM_WAIT);
        timer_enable = (state_q == MEM_WAIT);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_AR;
                end
            end
            LOAD_AR: begin
                ar_d    = bus_in;
                state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                // An ack in the final allowed cycle still counts as a successful fetch.
                if (mem_ack) begin
                    ir_d     = mem_rdata;
                    pc_inc_d = 1'b1;
                    state_d  = HOLD;
                end else if (timer_expired) begin
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            HOLD: begin
                if (ir_taken) begin
                    state_d = start ? LOAD_AR : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ar_q        <= '0;
            ir_q        <= '0;
            pc_inc_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_q        <= ar_d;
            ir_q        <= ir_d;
            pc_inc_q    <= pc_inc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Pulses are registered, so they appear in the cycle after the deciding edge.
    assign bus_sel   = fetch_bus_sel(state_q, SEL_PC);
    assign bus_own   = (state_q == LOAD_AR);
    assign mem_req   = (state_q == MEM_WAIT);
    assign mem_addr  = ar_q;
    assign pc_inc    = pc_inc_q;
    assign ir_out    = ir_q;
    assign ir_valid  = (state_q == HOLD);
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch, checked against a cycle-schedule model of each fetch.
module tb_instr_fetch;

    localparam int         DATA_W  = 16;
    localparam int         TIMEOUT = 15;
    localparam logic [3:0] PC_CODE = 4'b1010;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        bus_sel;
    logic              bus_own;
    logic [DATA_W-1:0] bus_in;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              pc_inc;
    logic [DATA_W-1:0] ir_out;
    logic              ir_valid;
    logic              ir_taken;
    logic              fetch_err;

    logic [DATA_W-1:0] pc_val;
    logic [DATA_W-1:0] junk_val;
    logic [DATA_W-1:0] exp_ir;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pc_inc_total = 0;
    int exp_err_total = 0;
    int got_pc_inc_total = 0;
    int got_err_total = 0;

    instr_fetch #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .SEL_PC  (PC_CODE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus_sel   (bus_sel),
        .bus_own   (bus_own),
        .bus_in    (bus_in),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_inc    (pc_inc),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_taken  (ir_taken),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    // Register-to-bus mux: PC only when the fetch block selects it, garbage otherwise.
    assign bus_in = (bus_own && bus_sel == PC_CODE) ? pc_val : junk_val;

    always @(negedge clk) begin
        if (pc_inc)    got_pc_inc_total++;
        if (fetch_err) got_err_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus_own"}, 32'(bus_own), 32'd0);
        chk({tag, "_bus_sel"}, 32'(bus_sel), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
        chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    endtask

    // Idle cycles with stray acks, which must have no effect.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            ir_taken  = 1'b0;
            mem_ack   = ($urandom_range(0, 1) == 1);
            mem_rdata = DATA_W'($urandom);
            junk_val  = DATA_W'($urandom);
            @(negedge clk);
            chk_quiet("idle");
            chk("idle_ir_out", 32'(ir_out), 32'(exp_ir));
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    // One fetch, cycle 0 = start seen in IDLE, cycle 1 = LOAD_AR, cycles 2..1+wl = wait.
    // d is the wait cycle carrying the ack (d > TIMEOUT means none arrives).
    task automatic run_fetch(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] rdata,
                             input int d, input int h, input bit started,
                             input bit chain, input bit spam);
        bit ok;
        int wl;
        int last;
        ok   = (d <= TIMEOUT);
        wl   = ok ? d : TIMEOUT;
        last = ok ? 2 + wl + h : 2 + wl;
        pc_val = pc;
        if (ok) exp_pc_inc_total++;
        else    exp_err_total++;
        for (int c = (started ? 1 : 0); c <= last; c++) begin
            junk_val  = DATA_W'($urandom);
            mem_rdata = DATA_W'($urandom);
            start     = 1'b0;
            ir_taken  = 1'b0;
            mem_ack   = 1'b0;
            if (c == 0) begin
                start   = 1'b1;
                mem_ack = spam && ($urandom_range(0, 1) == 1);
            end else if (c <= 1 + wl) begin
                start = spam && ($urandom_range(0, 1) == 1);
                if (ok && c == 1 + wl) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end else if (c == 1) begin
                    mem_ack = spam && ($urandom_range(0, 1) == 1);
                end
            end else if (ok) begin
                if (c == last) begin
                    ir_taken = 1'b1;
                    start    = chain;
                end else begin
                    start = spam && ($urandom_range(0, 1) == 1);
                end
                mem_ack = spam && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            if (ok && c == 2 + wl) exp_ir = rdata;
            chk("bus_own", 32'(bus_own), 32'(c == 1));
            chk("bus_sel", 32'(bus_sel), (c == 1) ? 32'(PC_CODE) : 32'd0);
            chk("mem_req", 32'(mem_req), 32'(c >= 2 && c <= 1 + wl));
            if (c >= 2) chk("mem_addr", 32'(mem_addr), 32'(pc));
            chk("ir_valid", 32'(ir_valid), 32'(ok && c >= 2 + wl));
            chk("pc_inc", 32'(pc_inc), 32'(ok && c == 2 + wl));
            chk("fetch_err", 32'(fetch_err), 32'(!ok && c == 2 + wl));
            chk("ir_out", 32'(ir_out), 32'(exp_ir));
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        ir_taken = 1'b0;
        mem_ack  = 1'b0;
    endtask

    initial begin
        bit prev_chain;
        rst_n     = 1'b0;
        start     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        ir_taken  = 1'b0;
        pc_val    = '0;
        junk_val  = 16'hDEAD;
        exp_ir    = '0;

        #12;
        chk_quiet("rst");
        chk("rst_ir_out", 32'(ir_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Basic fetch with ack in the second wait cycle: ir_valid at cycle 4.
        run_fetch(16'h0040, 16'hA5C3, 2, 1, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Minimum latency.
        run_fetch(16'h0041, 16'h1111, 1, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // No ack at all: one error, IR keeps its old value.
        run_fetch(16'h0042, 16'h2222, TIMEOUT + 1, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        // Ack on the exact timeout cycle wins.
        run_fetch(16'h0043, 16'h3333, TIMEOUT, 0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // Back-to-back fetch via ir_taken together with start.
        run_fetch(16'h0050, 16'h5A5A, 3, 2, 1'b0, 1'b1, 1'b0);
        run_fetch(16'h0051, 16'hC3C3, 1, 0, 1'b1, 1'b0, 1'b0);
        idle(1);
        // Stray start and ack during wait and hold.
        run_fetch(16'h0060, 16'h7E57, 5, 3, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of the wait state.
        pc_val = 16'h0070;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_ir = '0;
        chk_quiet("arst");
        chk("arst_ir_out", 32'(ir_out), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        run_fetch(16'h0080, 16'h0F0F, 2, 1, 1'b0, 1'b0, 1'b0);
        idle(1);

        prev_chain = 1'b0;
        for (int i = 0; i < 40; i++) begin
            int d;
            bit chain;
            d = (($urandom_range(0, 4) == 0)) ? int'($urandom_range(TIMEOUT, TIMEOUT + 2))
                                              : int'($urandom_range(1, 6));
            chain = (d <= TIMEOUT) && ($urandom_range(0, 1) == 1) && (i != 39);
            run_fetch(DATA_W'($urandom), DATA_W'($urandom), d, int'($urandom_range(0, 3)),
                      prev_chain, chain, $urandom_range(0, 1) == 1);
            prev_chain = chain;
            if (!chain) idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        chk("pc_inc_total", 32'(got_pc_inc_total), 32'(exp_pc_inc_total));
        chk("fetch_err_total", 32'(got_err_total), 32'(exp_err_total));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_W, default 16, width of bus, address, and instruction words.
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for mem_ack (1..255).
REQ-003 Parameter SEL_PC, default 4'b1010, bus select code that routes PC onto the data bus.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle request from the control unit to fetch the next instruction.
REQ-007 bus_sel  output  4  select code driven to the register-to-bus mux.
REQ-008 bus_own  output  1  high while this block owns bus_sel.
REQ-009 bus_in  input  DATA_W  data bus, the combinational output of the mux.
REQ-010 mem_req  output  1  memory read request, level.
REQ-011 mem_addr  output  DATA_W  read address, equal to the internal AR.
REQ-012 mem_ack  input  1  memory read data valid, one cycle.
REQ-013 mem_rdata  input  DATA_W  memory read data.
REQ-014 pc_inc  output  1  one-cycle pulse telling the PC register to increment.
REQ-015 ir_out  output  DATA_W  fetched instruction.
REQ-016 ir_valid  output  1  ir_out holds a fresh instruction.
REQ-017 ir_taken  input  1  decoder consumes ir_out.
REQ-018 fetch_err  output  1  one-cycle pulse on memory timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD_AR, MEM_WAIT, and HOLD.
REQ-020 In IDLE, start=1 SHALL go to LOAD_AR; otherwise the FSM stays in IDLE.
REQ-021 In LOAD_AR, bus_sel=SEL_PC and bus_own=1; AR SHALL capture bus_in at the clock edge; the next state is MEM_WAIT.
REQ-022 In MEM_WAIT, mem_req=1 and mem_addr=AR; the wait counter SHALL increment each cycle.
REQ-023 mem_ack=1 in MEM_WAIT SHALL capture mem_rdata into IR, pulse pc_inc for exactly that one cycle, and go to HOLD.
REQ-024 If the counter reaches TIMEOUT with no ack, the block SHALL pulse fetch_err for one cycle, leave IR unchanged, issue no pc_inc, and return to IDLE.
REQ-025 mem_ack on the same cycle as the timeout SHALL win: the fetch succeeds and no error is raised.
REQ-026 In HOLD, ir_valid=1 and ir_out is stable; ir_taken=1 SHALL go to IDLE, clearing ir_valid on the next cycle.
REQ-027 In HOLD, ir_taken=1 together with start=1 SHALL go directly to LOAD_AR (back-to-back fetch).
REQ-028 start in LOAD_AR or MEM_WAIT, and start in HOLD without ir_taken, SHALL be ignored and not queued.
REQ-029 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-030 Outside LOAD_AR, bus_sel SHALL be 4'b0000 and bus_own 0.
REQ-031 All outputs SHALL be registered or decoded from state only; no combinational path from any input to any output.
REQ-032 Minimum fetch latency SHALL be 3 cycles: start at cycle 0, ir_valid high at cycle 3 when mem_ack arrives in the first MEM_WAIT cycle.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, AR=0, IR=0, counter=0, all outputs 0.
REQ-034 Reset mid-fetch SHALL abandon the fetch with no pc_inc and no fetch_err; the first start after release behaves normally.

Structure
REQ-035 A shared package SHALL hold the FSM state encoding and the bus select codes (SEL_PC, SEL_DR, SEL_AC, and the rest).
REQ-036 The timeout counter SHALL be a sub-module, fetch_timer, with clear, enable, and expired ports.

Verification
REQ-037 PC=16'h0040, start, ack on the 2nd MEM_WAIT cycle with rdata=16'hA5C3 -> mem_addr=0040, one pc_inc, ir_out=A5C3, ir_valid high at cycle 4.
REQ-038 No ack -> exactly one fetch_err after TIMEOUT=15 MEM_WAIT cycles, no pc_inc, IR unchanged, FSM in IDLE.
REQ-039 Ack on the exact timeout cycle -> success, fetch_err stays 0.
REQ-040 ir_taken and start on the same HOLD cycle -> LOAD_AR next cycle, bus_sel=1010.
REQ-041 rst_n low during MEM_WAIT -> all outputs 0 asynchronously; no pc_inc or fetch_err after release.
REQ-042 start pulsed during MEM_WAIT and during HOLD -> no extra fetch and no change to ir_out.
